// File: rtl/stopwatch_display_core.sv
`timescale 1ns/1ps
// stopwatch_display_core: MM:SS stopwatch with run/pause/adjust modes and a
// multiplexed common-anode 4-digit seven-segment driver, all in master_clk.
module stopwatch_display_core (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       one_hertz,
    input  logic       two_hertz,
    input  logic       fast_hertz,
    input  logic       blink_hertz,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       running
);
    logic       prev_one, prev_two, prev_fast;
    logic       tick_one, tick_two, tick_fast;
    logic       run_flag, inc_run, inc_adj, blank;
    logic [7:0] secs, mins;
    logic [1:0] idx;
    logic [3:0] digit, an_next;
    logic [6:0] seg_next;

    // BCD two-digit increment wrapping 59 -> 00
    function automatic logic [7:0] bump(input logic [7:0] v);
        return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                              : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick_one  = one_hertz & ~prev_one;
    assign tick_two  = two_hertz & ~prev_two;
    assign tick_fast = fast_hertz & ~prev_fast;
    assign inc_run   = tick_one & run_flag & ~adj;
    assign inc_adj   = tick_two & adj;
    assign running   = run_flag;

    always_comb begin
        digit   = idx == 2'd0 ? secs[3:0] : idx == 2'd1 ? secs[7:4] :
                  idx == 2'd2 ? mins[3:0] : mins[7:4];
        blank   = adj & blink_hertz & (idx[1] ^ sel);
        an_next = blank ? 4'hF : ~(4'b0001 << idx);
        case (digit)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h7F;
        endcase
    end

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            prev_one  <= 1'b0;
            prev_two  <= 1'b0;
            prev_fast <= 1'b0;
            run_flag  <= 1'b0;
            idx       <= 2'd0;
            secs      <= 8'h00;
            mins      <= 8'h00;
            seg       <= 7'h7F;
            an        <= 4'hF;
        end else begin
            prev_one  <= one_hertz;
            prev_two  <= two_hertz;
            prev_fast <= fast_hertz;
            run_flag  <= run_flag ^ pause_pulse;
            idx       <= idx + {1'b0, tick_fast};
            if (inc_run) begin
                secs <= bump(secs);
                if (secs == 8'h59)
                    mins <= bump(mins);
            end else if (inc_adj && sel)
                secs <= bump(secs);
            else if (inc_adj)
                mins <= bump(mins);
            seg <= seg_next;
            an  <= an_next;
        end
    end
endmodule

// File: tb/tb_stopwatch_display_core.sv
`timescale 1ns/1ps
// tb_stopwatch_display_core: directed scenario tasks with hand-computed
// display expectations for the stopwatch core.
module tb_stopwatch_display_core;
    logic       master_clk = 0, reset = 1;
    logic       one_hertz = 0, two_hertz = 0, fast_hertz = 0, blink_hertz = 0;
    logic       pause_pulse = 0, adj = 0, sel = 0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       running;
    logic [6:0] disp [4];
    int         compared = 0, mismatched = 0;

    localparam int ONE = 0, TWO = 1;

    stopwatch_display_core dut (
        .master_clk(master_clk), .reset(reset), .one_hertz(one_hertz),
        .two_hertz(two_hertz), .fast_hertz(fast_hertz), .blink_hertz(blink_hertz),
        .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
        .seg(seg), .an(an), .running(running)
    );

    always #5 master_clk = ~master_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1);
    end

    function automatic logic [6:0] want(input int mm, input int ss, input int j);
        int d;
        d = j == 0 ? ss % 10 : j == 1 ? ss / 10 : j == 2 ? mm % 10 : mm / 10;
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    task automatic rise(input int w, input int n);
        repeat (n) begin
            @(posedge master_clk); #1;
            if (w == ONE) one_hertz = 1; else two_hertz = 1;
            @(posedge master_clk); #1;
            if (w == ONE) one_hertz = 0; else two_hertz = 0;
        end
        @(posedge master_clk); #1;
    endtask

    task automatic pause_now();
        @(posedge master_clk); #1 pause_pulse = 1;
        @(posedge master_clk); #1 pause_pulse = 0;
    endtask

    // one full scan: four fast_hertz edges, capturing seg per lit anode
    task automatic read_disp();
        for (int k = 0; k < 4; k++) disp[k] = 'x;
        for (int k = 0; k < 4; k++) begin
            @(posedge master_clk); #1 fast_hertz = 1;
            repeat (2) @(posedge master_clk);
            @(negedge master_clk);
            for (int j = 0; j < 4; j++)
                if (an == ~(4'b0001 << j)) disp[j] = seg;
            fast_hertz = 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge master_clk);
        @(negedge master_clk);
        compared++; if (an !== 4'hF) begin mismatched++; $display("FAIL reset_an got %b want 1111", an); end
        compared++; if (seg !== 7'h7F) begin mismatched++; $display("FAIL reset_seg got %h want 7f", seg); end
        compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL reset_running got %b want 0", running); end
        @(posedge master_clk); #1 reset = 0;
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 0, j)) begin mismatched++; $display("FAIL reset_time d%0d got %h want %h", j, disp[j], want(0, 0, j)); end
        end
    endtask

    task automatic test_run_carry();
        pause_now();
        compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL run_flag got %b want 1", running); end
        rise(ONE, 61);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(1, 1, j)) begin mismatched++; $display("FAIL run_0101 d%0d got %h want %h", j, disp[j], want(1, 1, j)); end
        end
        pause_now();
        adj = 1; sel = 0; rise(TWO, 58);
        sel = 1; rise(TWO, 57);
        adj = 0;
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(59, 58, j)) begin mismatched++; $display("FAIL preload_5958 d%0d got %h want %h", j, disp[j], want(59, 58, j)); end
        end
        pause_now();
        rise(ONE, 2);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 0, j)) begin mismatched++; $display("FAIL wrap_0000 d%0d got %h want %h", j, disp[j], want(0, 0, j)); end
        end
        pause_now();
    endtask

    task automatic test_pause();
        pause_now();
        rise(ONE, 5);
        pause_now();
        rise(ONE, 10);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 5, j)) begin mismatched++; $display("FAIL paused_0005 d%0d got %h want %h", j, disp[j], want(0, 5, j)); end
        end
        pause_now();
        rise(ONE, 1);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 6, j)) begin mismatched++; $display("FAIL resume_0006 d%0d got %h want %h", j, disp[j], want(0, 6, j)); end
        end
        @(posedge master_clk); #1 one_hertz = 1; pause_pulse = 1;
        @(posedge master_clk); #1 pause_pulse = 0;
        @(posedge master_clk); #1 one_hertz = 0;
        @(posedge master_clk); #1;
        compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL coincident_running got %b want 0", running); end
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 7, j)) begin mismatched++; $display("FAIL coincident_0007 d%0d got %h want %h", j, disp[j], want(0, 7, j)); end
        end
    endtask

    task automatic test_adjust();
        pause_now();
        @(posedge master_clk); #1 adj = 1; one_hertz = 1;
        @(posedge master_clk); #1 one_hertz = 0;
        @(posedge master_clk); #1;
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 7, j)) begin mismatched++; $display("FAIL adj_rise_tick d%0d got %h want %h", j, disp[j], want(0, 7, j)); end
        end
        sel = 1;
        rise(TWO, 51);
        rise(TWO, 3);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 1, j)) begin mismatched++; $display("FAIL adj_sec_wrap d%0d got %h want %h", j, disp[j], want(0, 1, j)); end
        end
        rise(ONE, 3);
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 1, j)) begin mismatched++; $display("FAIL adj_ignore_one d%0d got %h want %h", j, disp[j], want(0, 1, j)); end
        end
        compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL adj_run_flag got %b want 1", running); end
        adj = 0;
        pause_now();
    endtask

    task automatic test_scan();
        logic [15:0] ea = 16'b1101_1011_0111_1110;
        logic [27:0] es = {7'h24, 7'h40, 7'h79, 7'h10};
        logic [3:0]  pa = 4'b1110;
        logic [6:0]  ps = 7'h10;
        adj = 1; sel = 0; rise(TWO, 10);
        sel = 1; rise(TWO, 28);
        adj = 0;
        repeat (2) @(posedge master_clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge master_clk); #1 fast_hertz = 1;
            @(posedge master_clk); @(negedge master_clk);
            compared++;
            if ({an, seg} !== {pa, ps}) begin mismatched++; $display("FAIL scan_early%0d got %b/%h want %b/%h", k, an, seg, pa, ps); end
            @(posedge master_clk); @(negedge master_clk);
            pa = ea[15-4*k -: 4];
            ps = es[27-7*k -: 7];
            compared++;
            if ({an, seg} !== {pa, ps}) begin mismatched++; $display("FAIL scan%0d got %b/%h want %b/%h", k, an, seg, pa, ps); end
            fast_hertz = 0;
        end
    endtask

    task automatic test_blink();
        logic [15:0] on_an  = 16'b1101_1111_1111_1110;
        logic [15:0] off_an = 16'b1101_1011_0111_1110;
        logic [3:0]  w;
        adj = 1; sel = 0; blink_hertz = 1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge master_clk); #1 fast_hertz = 1;
                repeat (2) @(posedge master_clk);
                @(negedge master_clk);
                w = p == 0 ? on_an[15-4*k -: 4] : off_an[15-4*k -: 4];
                compared++;
                if (an !== w) begin mismatched++; $display("FAIL blink%0d_%0d got %b want %b", p, k, an, w); end
                fast_hertz = 0;
            end
            blink_hertz = 0;
        end
        adj = 0;
    endtask

    task automatic test_reset_mid();
        adj = 1; sel = 0; rise(TWO, 2);
        sel = 1; rise(TWO, 5);
        adj = 0;
        pause_now();
        @(posedge master_clk); #3 reset = 1;
        #1;
        compared++; if (an !== 4'hF) begin mismatched++; $display("FAIL mid_reset_an got %b want 1111", an); end
        compared++; if (seg !== 7'h7F) begin mismatched++; $display("FAIL mid_reset_seg got %h want 7f", seg); end
        compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL mid_reset_running got %b want 0", running); end
        @(posedge master_clk); #1 reset = 0;
        read_disp();
        for (int j = 0; j < 4; j++) begin
            compared++;
            if (disp[j] !== want(0, 0, j)) begin mismatched++; $display("FAIL mid_reset_time d%0d got %h want %h", j, disp[j], want(0, 0, j)); end
        end
    endtask

    initial begin
        test_reset();
        test_run_carry();
        test_pause();
        test_adjust();
        test_scan();
        test_blink();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
